// File: rtl/tree_fanout_node.sv
// Tree node: takes one command from the parent, sends it to one child or to all children, and returns one combined response with a timeout.
// Latency: dn_valid in the cycle after accept, rsp_valid one cycle after the last counted done, and a bad index answers in the cycle after accept.
// Backpressure: each dn_valid bit stays up until its dn_ready, and the response is held until rsp_ready; up_ready is high only in IDLE.
module tree_fanout_node #(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 32,
    parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic                    up_bcast,
    input  logic [IDX_W-1:0]        up_idx,
    input  logic [DATA_W-1:0]       up_data,
    output logic [NUM_CHILDREN-1:0] dn_valid,
    input  logic [NUM_CHILDREN-1:0] dn_ready,
    output logic [DATA_W-1:0]       dn_data,
    input  logic [NUM_CHILDREN-1:0] ch_done,
    input  logic [NUM_CHILDREN-1:0] ch_err,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_status,
    output logic [NUM_CHILDREN-1:0] rsp_mask
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BAD_IDX = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              status_q, status_nxt;
    logic [DATA_W-1:0]       data_q;
    logic [NUM_CHILDREN-1:0] target_q, issued_q, done_q, err_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_CHILDREN-1:0] hs, done_new, onehot;
    logic                    idx_bad;

    assign idx_bad    = !up_bcast && (int'(up_idx) >= NUM_CHILDREN);
    assign onehot     = NUM_CHILDREN'(1) << up_idx;
    assign dn_data    = data_q;
    assign rsp_status = status_q;
    assign rsp_mask   = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            status_q <= ST_OK;
        end else begin
            state    <= state_nxt;
            status_q <= status_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        status_nxt = status_q;
        up_ready   = 1'b0;
        dn_valid   = '0;
        rsp_valid  = 1'b0;
        hs         = '0;
        done_new   = '0;
        case (state)
            S_IDLE: begin
                up_ready = 1'b1;
                if (up_valid) begin
                    state_nxt  = idx_bad ? S_RESP : S_ISSUE;
                    status_nxt = idx_bad ? ST_BAD_IDX : ST_OK;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (state == S_ISSUE) dn_valid = target_q & ~issued_q;
                hs = dn_valid & dn_ready;
                // A child only counts once its command has actually been handed over.
                done_new = ch_done & target_q & (issued_q | hs) & ~done_q;
                if ((done_q | done_new) == target_q) begin
                    state_nxt  = S_RESP;
                    status_nxt = |(err_q | (done_new & ch_err)) ? ST_ERR : ST_OK;
                end else if (cnt_q == CNT_LAST) begin
                    state_nxt  = S_RESP;
                    status_nxt = ST_TIMEOUT;
                end else if (state == S_ISSUE && ((issued_q | hs) & target_q) == target_q) begin
                    state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst) up_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            target_q <= '0;
            issued_q <= '0;
            done_q   <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (up_valid) begin
                        data_q   <= up_data;
                        target_q <= up_bcast ? '1 : (idx_bad ? '0 : onehot);
                        issued_q <= '0;
                        done_q   <= '0;
                        err_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    issued_q <= issued_q | hs;
                    done_q   <= done_q | done_new;
                    err_q    <= err_q | (done_new & ch_err);
                    if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tree_fanout_node.sv
// Directed bench for tree_fanout_node (10 children, 16-cycle timeout).
module tb_tree_fanout_node;
    logic        clk;
    logic        rst;
    logic        up_valid, up_ready, up_bcast;
    logic [3:0]  up_idx;
    logic [31:0] up_data, dn_data;
    logic [9:0]  dn_valid, dn_ready, ch_done, ch_err, rsp_mask;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_status;
    int          n_checks = 0;
    int          n_fail   = 0;

    tree_fanout_node #(.NUM_CHILDREN(10), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_bcast(up_bcast),
        .up_idx(up_idx), .up_data(up_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
        .ch_done(ch_done), .ch_err(ch_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_mask(rsp_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic bcast, input logic [3:0] idx, input logic [31:0] data);
        up_valid = 1'b1; up_bcast = bcast; up_idx = idx; up_data = data;
        tick();
        up_valid = 1'b0; up_bcast = 1'b0; up_idx = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL rst_up_ready: got %b want 0", up_ready); end
        n_checks++; if (dn_valid !== 10'h000) begin n_fail++; $display("FAIL rst_dn_valid: got %h want 000", dn_valid); end
        n_checks++; if (dn_data !== 32'h0) begin n_fail++; $display("FAIL rst_dn_data: got %h want 0", dn_data); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_status !== 2'b00 || rsp_mask !== 10'h000) begin n_fail++; $display("FAIL rst_rsp: got %b/%h want 00/000", rsp_status, rsp_mask); end
        rst = 1'b0;
        #1;
        n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_up_ready: got %b want 1", up_ready); end
    endtask

    task automatic test_unicast();
        accept(1'b0, 4'd3, 32'hA5A5_0003);
        dn_ready = 10'h008;                                    // T+1
        n_checks++; if (dn_valid !== 10'h008) begin n_fail++; $display("FAIL uni_dn_valid: got %h want 008", dn_valid); end
        n_checks++; if (dn_data !== 32'hA5A5_0003) begin n_fail++; $display("FAIL uni_dn_data: got %h want a5a50003", dn_data); end
        n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL uni_up_ready_busy: got %b want 0", up_ready); end
        tick();                                                // T+2
        dn_ready = 10'h000; ch_done = 10'h020;                 // non-targeted done is ignored
        n_checks++; if (dn_valid !== 10'h000) begin n_fail++; $display("FAIL uni_dn_valid_drop: got %h want 000", dn_valid); end
        tick();                                                // T+3
        ch_done = 10'h000;
        tick();                                                // T+4
        ch_done = 10'h008;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL uni_rsp_early: got %b want 0", rsp_valid); end
        tick();                                                // T+5
        ch_done = 10'h000;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL uni_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_status !== 2'b00) begin n_fail++; $display("FAIL uni_status: got %b want 00", rsp_status); end
        n_checks++; if (rsp_mask !== 10'h008) begin n_fail++; $display("FAIL uni_mask: got %h want 008", rsp_mask); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (up_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL uni_return_idle: got up_ready=%b rsp_valid=%b want 1/0", up_ready, rsp_valid); end
    endtask

    task automatic test_broadcast();
        logic [9:0] exp_v;
        logic [9:0] done_tab [5] = '{10'h180, 10'h060, 10'h018, 10'h006, 10'h001};
        accept(1'b1, 4'd0, 32'h1234_5678);
        for (int k = 1; k <= 10; k++) begin                    // child k-1 accepts in cycle k
            dn_ready = 10'(1) << (k - 1);
            ch_done  = (k == 10) ? 10'h200 : 10'h000;          // child 9 done with its handshake
            exp_v    = 10'(10'h3FF << (k - 1));
            n_checks++; if (dn_valid !== exp_v) begin n_fail++; $display("FAIL bc_dn_valid[%0d]: got %h want %h", k, dn_valid, exp_v); end
            tick();
        end
        dn_ready = 10'h000;
        n_checks++; if (dn_valid !== 10'h000) begin n_fail++; $display("FAIL bc_dn_valid_done: got %h want 000", dn_valid); end
        for (int j = 0; j < 5; j++) begin                      // cycles 11..15, reverse order
            ch_done = done_tab[j];
            ch_err  = (j == 0) ? 10'h080 : 10'h000;
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bc_rsp_early[%0d]: got %b want 0", j, rsp_valid); end
            tick();
        end
        ch_done = 10'h000; ch_err = 10'h000;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bc_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_status !== 2'b01) begin n_fail++; $display("FAIL bc_status: got %b want 01", rsp_status); end
        n_checks++; if (rsp_mask !== 10'h3FF) begin n_fail++; $display("FAIL bc_mask: got %h want 3ff", rsp_mask); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_bad_index();
        accept(1'b0, 4'd12, 32'hBAD0_000C);
        n_checks++; if (dn_valid !== 10'h000) begin n_fail++; $display("FAIL bad_dn_valid: got %h want 000", dn_valid); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bad_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_status !== 2'b11) begin n_fail++; $display("FAIL bad_status: got %b want 11", rsp_status); end
        n_checks++; if (rsp_mask !== 10'h000) begin n_fail++; $display("FAIL bad_mask: got %h want 000", rsp_mask); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_exact_timeout();
        accept(1'b0, 4'd2, 32'h0000_0002);
        dn_ready = 10'h004;                                    // cycle 1
        tick();
        dn_ready = 10'h000;
        repeat (14) tick();                                    // cycle 16: last cycle before timeout
        ch_done = 10'h004;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL edge_rsp_early: got %b want 0", rsp_valid); end
        tick();
        ch_done = 10'h000;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00) begin n_fail++; $display("FAIL edge_status: got valid=%b status=%b want 1/00", rsp_valid, rsp_status); end
        n_checks++; if (rsp_mask !== 10'h004) begin n_fail++; $display("FAIL edge_mask: got %h want 004", rsp_mask); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Leaves the timeout response pending for test_rsp_hold.
    task automatic test_timeout();
        accept(1'b1, 4'd0, 32'h0000_0010);
        dn_ready = 10'h3DF;                                    // cycle 1: child 5 never accepts
        tick();
        dn_ready = 10'h000; ch_done = 10'h3DF;                 // cycle 2
        tick();
        ch_done = 10'h020;                                     // cycle 3: child 5 not issued, ignored
        tick();
        ch_done = 10'h000;
        repeat (12) tick();                                    // cycle 16
        n_checks++; if (dn_valid !== 10'h020) begin n_fail++; $display("FAIL to_dn_valid_held: got %h want 020", dn_valid); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_rsp_early: got %b want 0", rsp_valid); end
        tick();                                                // cycle 17
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL to_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_status !== 2'b10) begin n_fail++; $display("FAIL to_status: got %b want 10", rsp_status); end
        n_checks++; if (rsp_mask !== 10'h3DF) begin n_fail++; $display("FAIL to_mask: got %h want 3df", rsp_mask); end
        n_checks++; if (dn_valid !== 10'h000) begin n_fail++; $display("FAIL to_dn_valid_drop: got %h want 000", dn_valid); end
    endtask

    task automatic test_rsp_hold();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_mask !== 10'h3DF) begin
                n_fail++; $display("FAIL hold_rsp[%0d]: got %b/%b/%h want 1/10/3df", i, rsp_valid, rsp_status, rsp_mask); end
            n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL hold_up_ready[%0d]: got %b want 0", i, up_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (up_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_up_ready: got up_ready=%b rsp_valid=%b want 1/0", up_ready, rsp_valid); end
        accept(1'b0, 4'd0, 32'hDEAD_BEEF);
        dn_ready = 10'h001;
        n_checks++; if (dn_valid !== 10'h001) begin n_fail++; $display("FAIL b2b_dn_valid: got %h want 001", dn_valid); end
        tick();                                                // WAIT
        dn_ready = 10'h000;
        rst = 1'b1;
        tick();
        n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_up_ready: got %b want 0", up_ready); end
        n_checks++; if (dn_valid !== 10'h000 || dn_data !== 32'h0) begin n_fail++; $display("FAIL midrst_dn: got %h/%h want 000/0", dn_valid, dn_data); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_status !== 2'b00 || rsp_mask !== 10'h000) begin
            n_fail++; $display("FAIL midrst_rsp: got %b/%b/%h want 0/00/000", rsp_valid, rsp_status, rsp_mask); end
        rst = 1'b0;
        tick();
        n_checks++; if (up_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got up_ready=%b rsp_valid=%b want 1/0", up_ready, rsp_valid); end
    endtask

    initial begin
        rst = 1'b1; up_valid = 1'b0; up_bcast = 1'b0; up_idx = '0; up_data = '0;
        dn_ready = '0; ch_done = '0; ch_err = '0; rsp_ready = 1'b0;
        test_reset();
        test_unicast();
        test_broadcast();
        test_bad_index();
        test_exact_timeout();
        test_timeout();
        test_rsp_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tree_fanout_node.md
# tree_fanout_node

Parametrised, handshaked tree node that replaces fixed-count, port-less instance fan-out in the module hierarchy. It accepts one command from its parent, dispatches it to one selected child or broadcasts it to all `NUM_CHILDREN` children, and collects per-child completion and error. It returns a single aggregated response upstream, with a timeout guard. One outstanding command at a time; nodes cascade by wiring `rsp_*` of a child node into this node's `ch_done`/`ch_err`.

## Interface

Parameters:
- `NUM_CHILDREN`, 10. Number of child ports; must be ≥1.
- `DATA_W`, 32. Command payload width.
- `IDX_W`, `$clog2(NUM_CHILDREN)` (min 1). Child index width.
- `TIMEOUT_CYC`, 255. Maximum cycles spent in ISSUE+WAIT before the command is aborted; must be ≥1.

Ports:
- `clk` in 1: sole clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `up_valid` in 1: parent command valid.
- `up_ready` out 1: node can accept a command.
- `up_bcast` in 1: 1 selects broadcast to all children; 0 selects unicast to `up_idx`.
- `up_idx` in IDX_W: target child for unicast.
- `up_data` in DATA_W: command payload.
- `dn_valid` out NUM_CHILDREN: per-child command valid.
- `dn_ready` in NUM_CHILDREN: per-child accept.
- `dn_data` out DATA_W: latched payload, shared by all children.
- `ch_done` in NUM_CHILDREN: per-child completion pulse.
- `ch_err` in NUM_CHILDREN: per-child error flag; sampled together with `ch_done`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: parent accepts the response.
- `rsp_status` out 2: response code.
  - 00 OK
  - 01 child error
  - 10 timeout
  - 11 bad index
- `rsp_mask` out NUM_CHILDREN: children that reported done.

## Operation

The node is an FSM with four states: IDLE, ISSUE, WAIT, RESP.

IDLE:
- `up_ready`=1.
- On `up_valid`, latch `up_data` into `dn_data`.
- Set `target` = broadcast ? all ones : onehot(`up_idx`).
- Clear `issued`, `done`, `err` and the timeout counter.
- If unicast and `up_idx` ≥ NUM_CHILDREN: go to RESP with status 11 and mask 0. Otherwise go to ISSUE.

ISSUE:
- `dn_valid[i]` = `target[i]` & ~`issued[i]`.
- When `dn_valid[i]` & `dn_ready[i]`, set `issued[i]`.
- When every targeted child is issued (counting handshakes in the current cycle), go to WAIT.

Done/error collection (ISSUE and WAIT):
- `ch_done[i]` counts only if `target[i]` and (`issued[i]` or handshake this cycle). It then sets `done[i]` and ORs `ch_err[i]` into `err[i]`.
- `ch_done` on non-targeted or not-yet-issued children is ignored.
- Repeated `ch_done` on an already-done child is ignored.
- When `done` == `target` (including this cycle's pulses), go to RESP.

Timeout:
- The counter increments every cycle spent in ISSUE/WAIT.
- If the counter reaches TIMEOUT_CYC−1 without completion, go to RESP with status 10. All `dn_valid` deassert on the next cycle.
- If completion and timeout occur in the same cycle, completion wins.

RESP:
- `rsp_valid`=1. `rsp_status` and `rsp_mask` (=`done`) are held stable until `rsp_ready`, then return to IDLE.
- Status priority: timeout > error (any `err`) > OK.

Reset: state IDLE; the following outputs are 0 and registers cleared:
- outputs: `up_ready`, `dn_valid`, `dn_data`, `rsp_valid`, `rsp_status`, `rsp_mask`
- registers: `target`, `issued`, `done`, `err`, counter

Asserting `rst` mid-command aborts it with no response. `up_ready`=0 while `rst` is high.

Counter width is `$clog2(TIMEOUT_CYC+1)`; it never wraps.

## Timing

- `up_ready` is a decode of state==IDLE; it is not combinationally dependent on `up_valid`.
- Accept at edge T: `dn_valid` is high in cycle T+1.
- Minimum latency: child ready and `ch_done` both in cycle T+1 give `rsp_valid` in cycle T+2.
- Bad index accepted at T gives `rsp_valid` in T+1.
- `dn_valid[i]` remains high until `dn_ready[i]`, except on timeout.
- Back-to-back: `rsp_ready` at edge R gives `up_ready`=1 in cycle R+1. One idle cycle between commands is the minimum.
- `dn_data` is stable from T+1 until the next accept.

## Test plan

- Unicast idx=3, data 0xA5A5_0003, child 3 `dn_ready`=1 at T+1, `ch_done[3]` at T+4 -> `dn_valid`=0x008 for exactly one cycle; `rsp_valid` at T+5 with status 00, mask 0x008.
- Broadcast, children accept staggered over cycles 1..10, done pulses in reverse order, `ch_err[7]` set with its done -> status 01, mask 0x3FF; each `dn_valid` bit drops individually on its handshake.
- Unicast idx=12 (NUM_CHILDREN=10) -> no `dn_valid`; `rsp_valid` the cycle after accept with status 11, mask 0.
- Broadcast, child 5 never asserts `ch_done`, TIMEOUT_CYC=16 -> `rsp_valid` 16 cycles after entering ISSUE, status 10, mask 0x3DF. Also: completion landing exactly on the timeout cycle yields status 00.
- `rsp_ready` held low 5 cycles -> `rsp_*` stable and `up_ready`=0 throughout. Then `rst` pulsed in WAIT of the next command -> all outputs 0 next cycle and IDLE afterwards.
